// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// load/store. One transaction is in flight at a time. The memory-side request
// is registered and held until ack. A watchdog aborts transactions that are
// never acknowledged.
//
// state | meaning
// IDLE  | no transaction in flight; a pending request is granted this cycle
// BUSY  | o_mem_* held stable, waiting for i_mem_ack or watchdog expiry
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DATA_PRIO = 0,
    parameter int TIMEOUT   = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_gnt,
    output logic                o_if_rvalid,
    input  logic                i_d_req,
    input  logic                i_d_we,
    input  logic [ADDR_W-1:0]   i_d_addr,
    input  logic [DATA_W-1:0]   i_d_wdata,
    input  logic [DATA_W/8-1:0] i_d_be,
    output logic                o_d_gnt,
    output logic                o_d_rvalid,
    output logic [DATA_W-1:0]   o_rdata,
    output logic                o_err,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_be,
    input  logic                i_mem_ack,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state_q;
    logic                owner_q;     // 1 = data port owns the transaction
    logic                last_q;      // 1 = data port won the last grant
    logic [CNT_W-1:0]    cnt_q;
    logic                if_gnt_q, d_gnt_q, if_rvalid_q, d_rvalid_q, err_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                mem_req_q, mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [BE_W-1:0]     mem_be_q;

    logic                win_data_d;
    logic                expire_d;

    // Winner selection for the current IDLE cycle; round-robin favours the
    // port that did not win last time.
    always_comb begin
        win_data_d = i_d_req;
        if (i_d_req && i_if_req) begin
            win_data_d = (DATA_PRIO != 0) ? 1'b1 : ~last_q;
        end
    end

    assign expire_d = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // Controller FSM with all outputs registered.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_if_req || i_d_req) begin
                        state_q   <= BUSY;
                        owner_q   <= win_data_d;
                        last_q    <= win_data_d;
                        cnt_q     <= '0;
                        mem_req_q <= 1'b1;
                        if (win_data_d) begin
                            mem_addr_q  <= i_d_addr;
                            mem_we_q    <= i_d_we;
                            mem_wdata_q <= i_d_wdata;
                            mem_be_q    <= i_d_be;
                            d_gnt_q     <= 1'b1;
                        end else begin
                            mem_addr_q  <= i_if_addr;
                            mem_we_q    <= 1'b0;
                            mem_wdata_q <= '0;
                            mem_be_q    <= '1;
                            if_gnt_q    <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Ack takes precedence over a simultaneous watchdog expiry.
                    if (i_mem_ack) begin
                        state_q     <= IDLE;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        if_rvalid_q <= ~owner_q;
                        d_rvalid_q  <= owner_q;
                        rdata_q     <= mem_we_q ? '0 : i_mem_rdata;
                    end else if (expire_d) begin
                        state_q     <= IDLE;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        if_rvalid_q <= ~owner_q;
                        d_rvalid_q  <= owner_q;
                        rdata_q     <= '0;
                        err_q       <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_if_gnt    = if_gnt_q;
    assign o_d_gnt     = d_gnt_q;
    assign o_if_rvalid = if_rvalid_q;
    assign o_d_rvalid  = d_rvalid_q;
    assign o_err       = err_q;
    assign o_rdata     = rdata_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_be    = mem_be_q;
    assign o_busy      = (state_q == BUSY);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: instance A is round-robin, instance B
// is data-priority; both use a 4-cycle watchdog.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        port;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } gexp_t;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } rexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A (round-robin) ----------------
    logic        a_if_req = 1'b0, a_d_req = 1'b0, a_d_we = 1'b0;
    logic [31:0] a_if_addr = '0, a_d_addr = '0, a_d_wdata = '0, a_mem_rdata_i = '0;
    logic [3:0]  a_d_be = '0;
    logic        a_ack_m = 1'b0, a_stray = 1'b0, a_ack;
    logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_err, a_mem_req, a_mem_we, a_busy;
    logic [31:0] a_rdata, a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_be;
    int          a_ack_lat = 1;
    int          a_busy_n = 0;
    assign a_ack = a_ack_m | a_stray;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(0), .TIMEOUT(4)) dut_a (
        .i_clk(clk), .i_reset(rst),
        .i_if_req(a_if_req), .i_if_addr(a_if_addr), .o_if_gnt(a_if_gnt), .o_if_rvalid(a_if_rvalid),
        .i_d_req(a_d_req), .i_d_we(a_d_we), .i_d_addr(a_d_addr), .i_d_wdata(a_d_wdata), .i_d_be(a_d_be),
        .o_d_gnt(a_d_gnt), .o_d_rvalid(a_d_rvalid), .o_rdata(a_rdata), .o_err(a_err),
        .o_mem_req(a_mem_req), .o_mem_we(a_mem_we), .o_mem_addr(a_mem_addr),
        .o_mem_wdata(a_mem_wdata), .o_mem_be(a_mem_be),
        .i_mem_ack(a_ack), .i_mem_rdata(a_mem_rdata_i), .o_busy(a_busy)
    );

    // ---------------- instance B (data priority) ----------------
    logic        b_if_req = 1'b0, b_d_req = 1'b0, b_ack = 1'b0;
    logic [31:0] b_if_addr = 32'h900, b_d_addr = 32'h800, b_d_wdata = '0, b_mem_rdata_i = 32'h55;
    logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_err, b_mem_req, b_mem_we, b_busy;
    logic [31:0] b_rdata, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_be;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(1), .TIMEOUT(4)) dut_b (
        .i_clk(clk), .i_reset(rst),
        .i_if_req(b_if_req), .i_if_addr(b_if_addr), .o_if_gnt(b_if_gnt), .o_if_rvalid(b_if_rvalid),
        .i_d_req(b_d_req), .i_d_we(1'b0), .i_d_addr(b_d_addr), .i_d_wdata(b_d_wdata), .i_d_be(4'hF),
        .o_d_gnt(b_d_gnt), .o_d_rvalid(b_d_rvalid), .o_rdata(b_rdata), .o_err(b_err),
        .o_mem_req(b_mem_req), .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr),
        .o_mem_wdata(b_mem_wdata), .o_mem_be(b_mem_be),
        .i_mem_ack(b_ack), .i_mem_rdata(b_mem_rdata_i), .o_busy(b_busy)
    );

    logic [107:0] a_outs, b_outs;
    assign a_outs = {a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_rdata, a_err, a_mem_req,
                     a_mem_we, a_mem_addr, a_mem_wdata, a_mem_be, a_busy};
    assign b_outs = {b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_rdata, b_err, b_mem_req,
                     b_mem_we, b_mem_addr, b_mem_wdata, b_mem_be, b_busy};

    gexp_t ga[$];
    rexp_t ra[$];
    logic  gb[$];
    rexp_t rb[$];
    gexp_t cur_a = '0;
    logic  rr_mode = 1'b0;
    int    last_gcyc = -1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s actual=unexpected required=none", nm);
    endtask

    // Memory models: A acks in its a_ack_lat-th BUSY cycle (never if -1), B acks at once.
    always @(negedge clk) begin
        if (a_mem_req) begin
            a_busy_n = a_busy_n + 1;
            a_ack_m  = (a_busy_n == a_ack_lat);
        end else begin
            a_busy_n = 0;
            a_ack_m  = 1'b0;
        end
        b_ack = b_mem_req;
    end

    // Monitor A: grants, held memory request, responses.
    always @(negedge clk) begin
        gexp_t ge;
        rexp_t re;
        if (!rst) begin
            if (a_if_gnt && a_d_gnt) fail_now("a_gnt_both");
            if (a_if_gnt || a_d_gnt) begin
                if (ga.size() == 0) fail_now("a_gnt_unexpected");
                else begin
                    ge = ga.pop_front();
                    chk("a_gnt", 128'({a_d_gnt, a_mem_addr, a_mem_we, a_mem_wdata, a_mem_be}), 128'(ge));
                    chk("a_gnt_mem_req", 128'(a_mem_req), 128'(1));
                    cur_a = ge;
                    if (rr_mode) begin
                        if (last_gcyc >= 0) chk("a_rr_spacing", 128'(cyc - last_gcyc), 128'(2));
                        last_gcyc = cyc;
                    end
                end
            end else if (a_mem_req) begin
                chk("a_mem_hold", 128'({cur_a.port, a_mem_addr, a_mem_we, a_mem_wdata, a_mem_be}), 128'(cur_a));
            end
            if (a_if_rvalid && a_d_rvalid) fail_now("a_rvalid_both");
            if (a_if_rvalid || a_d_rvalid) begin
                if (ra.size() == 0) fail_now("a_rvalid_unexpected");
                else begin
                    re = ra.pop_front();
                    chk("a_rsp", 128'({a_d_rvalid, a_rdata, a_err}), 128'(re));
                end
            end else if (a_err) fail_now("a_err_without_rvalid");
        end
    end

    // Monitor B: grant order and responses.
    always @(negedge clk) begin
        rexp_t re;
        logic  gp;
        if (!rst) begin
            if (b_if_gnt || b_d_gnt) begin
                if (gb.size() == 0) fail_now("b_gnt_unexpected");
                else begin
                    gp = gb.pop_front();
                    chk("b_gnt_port", 128'({b_if_gnt, b_d_gnt}), 128'({~gp, gp}));
                end
            end
            if (b_if_rvalid || b_d_rvalid) begin
                if (rb.size() == 0) fail_now("b_rvalid_unexpected");
                else begin
                    re = rb.pop_front();
                    chk("b_rsp", 128'({b_d_rvalid, b_rdata, b_err}), 128'(re));
                end
            end
        end
    end

    // One single-port transaction on instance A; returns at the cycle after the request drops.
    task automatic run_a(input logic is_d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] mem_rdata, input int lat,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_busy);
        int n;
        ga.push_back('{port: is_d, addr: addr, we: is_d ? we : 1'b0,
                       wdata: is_d ? wdata : 32'h0, be: is_d ? be : 4'hF});
        ra.push_back('{port: is_d, rdata: exp_rdata, err: exp_err});
        a_ack_lat     = lat;
        a_mem_rdata_i = mem_rdata;
        if (is_d) begin
            a_d_we = we; a_d_addr = addr; a_d_wdata = wdata; a_d_be = be; a_d_req = 1'b1;
        end else begin
            a_if_addr = addr; a_if_req = 1'b1;
        end
        @(negedge clk);
        chk("a_gnt_latency", 128'(is_d ? a_d_gnt : a_if_gnt), 128'(1));
        // Requester moves on as soon as it is granted.
        a_if_req = 1'b0; a_d_req = 1'b0;
        a_if_addr = 32'hFFFF_FFFF; a_d_addr = 32'hFFFF_FFFF;
        a_d_wdata = ~wdata; a_d_we = ~we; a_d_be = 4'h0;
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!a_mem_req) break;
            n++;
        end
        chk("a_busy_cycles", 128'(n), 128'(exp_busy));
    endtask

    initial begin
        int ng;
        int nd;
        logic got_f;

        repeat (3) @(negedge clk);
        chk("a_reset_outs", 128'(a_outs), 128'(0));
        chk("b_reset_outs", 128'(b_outs), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("a_idle_outs", 128'(a_outs), 128'(0));

        // Round-robin contention from reset: data, fetch, data, fetch.
        a_d_we = 1'b0; a_d_addr = 32'h300; a_d_wdata = 32'h0; a_d_be = 4'hF;
        a_if_addr = 32'h400; a_ack_lat = 1; a_mem_rdata_i = 32'h1111_2222;
        for (int k = 0; k < 4; k++) begin
            ga.push_back('{port: ~k[0], addr: k[0] ? 32'h400 : 32'h300, we: 1'b0, wdata: 32'h0, be: 4'hF});
            ra.push_back('{port: ~k[0], rdata: 32'h1111_2222, err: 1'b0});
        end
        rr_mode = 1'b1;
        a_if_req = 1'b1; a_d_req = 1'b1;
        ng = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (a_if_gnt || a_d_gnt) ng++;
            if (ng == 4) break;
        end
        a_if_req = 1'b0; a_d_req = 1'b0;
        chk("a_rr_grants", 128'(ng), 128'(4));
        repeat (2) @(negedge clk);
        rr_mode = 1'b0;

        // Data priority: data wins four times, fetch only after data drops.
        for (int k = 0; k < 4; k++) begin
            gb.push_back(1'b1);
            rb.push_back('{port: 1'b1, rdata: 32'h55, err: 1'b0});
        end
        gb.push_back(1'b0);
        rb.push_back('{port: 1'b0, rdata: 32'h55, err: 1'b0});
        b_if_req = 1'b1; b_d_req = 1'b1;
        nd = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (b_d_gnt) nd++;
            if (nd == 4) break;
        end
        b_d_req = 1'b0;
        chk("b_data_grants", 128'(nd), 128'(4));
        got_f = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_if_gnt) begin
                got_f = 1'b1;
                break;
            end
        end
        b_if_req = 1'b0;
        chk("b_fetch_after_drop", 128'(got_f), 128'(1));
        repeat (2) @(negedge clk);

        // Fetch, immediate ack.
        run_a(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1'b0, 1);
        // Store, ack in third BUSY cycle; memory read data must not be returned.
        run_a(1'b1, 1'b1, 32'h200, 32'h1234_5678, 4'h3, 32'hFFFF_FFFF, 3, 32'h0, 1'b0, 3);
        // Load never acknowledged: watchdog abort.
        run_a(1'b1, 1'b0, 32'h500, 32'hAAAA_5555, 4'hF, 32'hCAFE_F00D, -1, 32'h0, 1'b1, 4);
        // Ack in the same cycle as expiry: ack wins.
        run_a(1'b0, 1'b0, 32'h600, 32'h0, 4'h0, 32'h0BAD_F00D, 4, 32'h0BAD_F00D, 1'b0, 4);

        // Reset while BUSY: transaction abandoned, outputs clear asynchronously.
        ga.push_back('{port: 1'b0, addr: 32'h700, we: 1'b0, wdata: 32'h0, be: 4'hF});
        a_ack_lat = -1; a_if_addr = 32'h700; a_if_req = 1'b1;
        @(negedge clk);
        chk("a_gnt_before_reset", 128'(a_if_gnt), 128'(1));
        a_if_req = 1'b0;
        @(negedge clk);
        chk("a_busy_before_reset", 128'({a_busy, a_mem_req}), 128'(2'b11));
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("a_async_reset", 128'(a_outs), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("a_after_reset", 128'(a_outs), 128'(0));

        // Stray ack in IDLE changes nothing.
        a_stray = 1'b1;
        @(negedge clk);
        a_stray = 1'b0;
        chk("a_stray_ack_idle", 128'(a_outs), 128'(0));
        @(negedge clk);
        chk("a_stray_ack_idle2", 128'(a_outs), 128'(0));

        chk("a_gnt_queue_empty", 128'(ga.size()), 128'(0));
        chk("a_rsp_queue_empty", 128'(ra.size()), 128'(0));
        chk("b_gnt_queue_empty", 128'(gb.size()), 128'(0));
        chk("b_rsp_queue_empty", 128'(rb.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
